// File: rtl/hd44780_rx_if.sv
// HD44780 4-bit bus as seen on the LCD pins: enable strobe, register
// select and the upper data nibble DB7..DB4. The LCD driver is the
// master; the receiver model is the slave.
interface hd44780_rx_if;
   logic       en;
   logic       rs;
   logic [3:0] data;

   modport master (output en, output rs, output data);
   modport slave  (input  en, input  rs, input  data);
endinterface

// File: rtl/hd44780_rx.sv
// Responder-side model of an HD44780 character LCD on a 4-bit bus.
// Synchronises the driver's en/rs/data, rebuilds bytes from nibbles,
// executes the driver's command subset and keeps a 2-row DDRAM image
// that on-chip consumers read through rd_row/rd_col.
// Optional feature: define LCD_SHIFT_EN to make cursor-shift commands
// (0001 S/C R/L xx with S/C=0) step the address counter; without it the
// whole 0001xxxx group is a no-op.
module hd44780_rx #(
   parameter int COLS         = 16,
   parameter int CLEAR_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   hd44780_rx_if.slave      bus,
   input  logic             rd_row,
   input  logic [5:0]       rd_col,
   output logic [7:0]       rd_char,
   output logic [6:0]       addr,
   output logic             four_bit,
   output logic             two_line,
   output logic             display_on,
   output logic             cursor_on,
   output logic             blink_on,
   output logic             busy,
   output logic             byte_valid,
   output logic             byte_rs,
   output logic [7:0]       byte_data,
   output logic             overrun
);

   localparam int WALK_LEN = 2 * COLS;
   localparam int IW       = $clog2(WALK_LEN);
   localparam int CW       = $clog2(CLEAR_CYCLES);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLR_WALK, ST_CLR_HOLD} state_t;
   typedef enum logic {PH_HIGH, PH_LOW} phase_t;

   logic          en_s1, en_s2, en_d;
   logic          rs_s1, rs_s2;
   logic [3:0]    d_s1, d_s2;
   logic          strobe, byte_done, exec, asm_rs;
   logic [7:0]    asm_byte;
   logic [3:0]    hi_nib;
   logic          hi_rs;
   phase_t        phase;
   logic          incdec;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          walk_we, clear_go, data_we;
   logic          wr_hit;
   logic [IW-1:0] wr_idx, rd_idx;
   logic          rd_ok;
   logic [7:0]    mem [WALK_LEN];

   function automatic logic [6:0] addr_inc(input logic [6:0] a);
      case (a)
         7'h27:   return 7'h40;
         7'h67:   return 7'h00;
         default: return a + 7'd1;
      endcase
   endfunction

   function automatic logic [6:0] addr_dec(input logic [6:0] a);
      case (a)
         7'h00:   return 7'h67;
         7'h40:   return 7'h27;
         default: return a - 7'd1;
      endcase
   endfunction

   // Two-flop synchronisers for the bus, plus one en delay stage for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_s1 <= 1'b0;
         en_s2 <= 1'b0;
         en_d  <= 1'b0;
         rs_s1 <= 1'b0;
         rs_s2 <= 1'b0;
         d_s1  <= 4'h0;
         d_s2  <= 4'h0;
      end else begin
         // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
         en_s1 <= bus.en;
         en_s2 <= en_s1;
         en_d  <= en_s2;
         rs_s1 <= bus.rs;
         rs_s2 <= rs_s1;
         d_s1  <= bus.data;
         d_s2  <= d_s1;
      end
   end

   // Strobe detection and byte assembly; a byte executes only when not busy.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      strobe    = en_d & ~en_s2;
      asm_byte  = {d_s2, 4'b0000};
      asm_rs    = rs_s2;
      byte_done = strobe;
      if (four_bit) begin
         asm_byte  = {hi_nib, d_s2};
         asm_rs    = hi_rs;
         byte_done = strobe & (phase == PH_LOW);
      end
      exec     = byte_done & ~busy;
      clear_go = exec & ~asm_rs & (asm_byte == 8'h01);
      data_we  = exec & asm_rs & wr_hit;
   end

   // Map the address counter onto a DDRAM index; unmapped addresses drop writes.
   always_comb begin
      wr_hit = 1'b0;
      wr_idx = '0;
      if (int'(addr) < COLS) begin
         wr_hit = 1'b1;
         wr_idx = IW'(addr);
      end else if (int'(addr) >= 'h40 && int'(addr) < 'h40 + COLS) begin
         wr_hit = 1'b1;
         wr_idx = IW'(int'(addr) - 'h40 + COLS);
      end
   end

   // Readout index; columns past the stored width read as a space.
   always_comb begin
      rd_ok  = int'(rd_col) < COLS;
      rd_idx = rd_row ? IW'(int'(rd_col) + COLS) : IW'(rd_col);
   end

   // Clear FSM state and cycle counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Clear FSM: the reset walk runs silently; a clear command walks, then holds busy.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      walk_we = 1'b0;
      case (state)
         ST_INIT: begin
            walk_we = 1'b1;
            if (cnt == CW'(WALK_LEN - 1)) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_IDLE: ;
         ST_CLR_WALK: begin
            walk_we = 1'b1;
            cnt_n   = cnt + 1'b1;
            if (cnt == CW'(CLEAR_CYCLES - 1)) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else if (cnt == CW'(WALK_LEN - 1)) begin
               state_n = ST_CLR_HOLD;
            end
         end
         ST_CLR_HOLD: begin
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(CLEAR_CYCLES - 1)) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (clear_go) begin
         state_n = ST_CLR_WALK;
         cnt_n   = '0;
      end
   end

   // Busy covers only a commanded clear, never the reset walk.
   always_comb busy = (state == ST_CLR_WALK) || (state == ST_CLR_HOLD);

   // DDRAM write port: walk fill, then executed data writes (data wins on a tie).
   // NOTE: the array has no reset; the walk fills it, so it can map onto a RAM.
   always_ff @(posedge clk) begin
      if (walk_we) mem[IW'(cnt)] <= 8'h20;
      if (data_we) mem[wr_idx]   <= asm_byte;
   end

   // Registered readout; a same-cycle write to the location returns the old byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_char <= 8'h20;
      else       rd_char <= rd_ok ? mem[rd_idx] : 8'h20;
   end

   // Nibble phase, byte report, overrun and command/data execution.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr       <= 7'h00;
         four_bit   <= 1'b0;
         two_line   <= 1'b0;
         display_on <= 1'b0;
         cursor_on  <= 1'b0;
         blink_on   <= 1'b0;
         incdec     <= 1'b1;
         phase      <= PH_HIGH;
         hi_nib     <= 4'h0;
         hi_rs      <= 1'b0;
         byte_valid <= 1'b0;
         byte_rs    <= 1'b0;
         byte_data  <= 8'h00;
         overrun    <= 1'b0;
      end else begin
         byte_valid <= byte_done;
         if (byte_done) begin
            byte_rs   <= asm_rs;
            byte_data <= asm_byte;
            if (busy) overrun <= 1'b1;
         end
         if (strobe && four_bit) begin
            if (phase == PH_HIGH) begin
               hi_nib <= d_s2;
               hi_rs  <= rs_s2;
               phase  <= PH_LOW;
            end else begin
               phase  <= PH_HIGH;
            end
         end
         if (exec) begin
            if (asm_rs) begin
               addr <= incdec ? addr_inc(addr) : addr_dec(addr);
            end else begin
               casez (asm_byte)
                  8'b1???????: addr <= asm_byte[6:0];
                  8'b01??????: ;
                  8'b001?????: begin
                     four_bit <= ~asm_byte[4];
                     two_line <= asm_byte[3];
                     phase    <= PH_HIGH;
                  end
                  8'b0001????: begin
`ifdef LCD_SHIFT_EN
                     if (!asm_byte[3]) addr <= asm_byte[2] ? addr_inc(addr) : addr_dec(addr);
`endif
                  end
                  8'b00001???: begin
                     display_on <= asm_byte[2];
                     cursor_on  <= asm_byte[1];
                     blink_on   <= asm_byte[0];
                  end
                  8'b000001??: incdec <= asm_byte[1];
                  8'b0000001?: addr <= 7'h00;
                  8'b00000001: begin
                     addr   <= 7'h00;
                     incdec <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_hd44780_rx.sv
// Self-checking bench for hd44780_rx: table of bus bytes with expected
// address/flag state, a scoreboard for reported bytes, and hand-written
// sequences for latency, clear timing, overrun and mid-clear reset.
module tb_hd44780_rx;
   localparam int COLS         = 16;
   localparam int CLEAR_CYCLES = 64;
   localparam int N_VEC        = 32;
   localparam int SPLIT        = 7;

`ifdef LCD_SHIFT_EN
   localparam logic [6:0] SHIFT_R_ADDR = 7'h06;
`else
   localparam logic [6:0] SHIFT_R_ADDR = 7'h05;
`endif

   localparam logic [4:0] F0   = 5'b00000;
   localparam logic [4:0] F8   = 5'b10000;
   localparam logic [4:0] F28  = 5'b11000;
   localparam logic [4:0] FON  = 5'b11100;
   localparam logic [4:0] FALL = 5'b11111;

   logic       clk = 1'b0;
   logic       reset;
   logic       rd_row;
   logic [5:0] rd_col;
   logic [7:0] rd_char;
   logic [6:0] addr;
   logic       four_bit, two_line, display_on, cursor_on, blink_on;
   logic       busy, byte_valid, byte_rs, overrun;
   logic [7:0] byte_data;

   hd44780_rx_if lcd_bus ();

   hd44780_rx #(.COLS(COLS), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (lcd_bus),
      .rd_row     (rd_row),
      .rd_col     (rd_col),
      .rd_char    (rd_char),
      .addr       (addr),
      .four_bit   (four_bit),
      .two_line   (two_line),
      .display_on (display_on),
      .cursor_on  (cursor_on),
      .blink_on   (blink_on),
      .busy       (busy),
      .byte_valid (byte_valid),
      .byte_rs    (byte_rs),
      .byte_data  (byte_data),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rs;
      logic [7:0] b;
   } sb_t;

   typedef struct {
      logic       four;
      logic       rs;
      logic [7:0] b;
      logic [6:0] exp_addr;
      logic [4:0] exp_flags;
   } vec_t;

   int   n_vec = 0;
   int   n_err = 0;
   sb_t  sb_q[$];
   sb_t  sb_head;
   vec_t vecs [N_VEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Scoreboard: every reported byte must match the oldest expected one.
   always @(negedge clk) begin
      if (!reset && byte_valid) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_unexpected: got rs=%0b data=%02h, required no byte", byte_rs, byte_data);
         end else begin
            sb_head = sb_q.pop_front();
            check("byte_data", 32'(byte_data), 32'(sb_head.b));
            check("byte_rs", 32'(byte_rs), 32'(sb_head.rs));
         end
      end
   end

   task automatic send_nib(input logic rs, input logic [3:0] nib);
      @(negedge clk);
      lcd_bus.rs   = rs;
      lcd_bus.data = nib;
      lcd_bus.en   = 1'b1;
      repeat (3) @(negedge clk);
      lcd_bus.en   = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic send8(input logic rs, input logic [7:0] b);
      sb_q.push_back('{rs: rs, b: {b[7:4], 4'h0}});
      send_nib(rs, b[7:4]);
   endtask

   task automatic send4(input logic rs, input logic [7:0] b);
      sb_q.push_back('{rs: rs, b: b});
      send_nib(rs, b[7:4]);
      send_nib(rs, b[3:0]);
   endtask

   task automatic read_cell(input logic row, input logic [5:0] col, input logic [7:0] req, input string name);
      @(negedge clk);
      rd_row = row;
      rd_col = col;
      @(posedge clk);
      @(negedge clk);
      check(name, 32'(rd_char), 32'(req));
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      if (v.four) send4(v.rs, v.b);
      else        send8(v.rs, v.b);
      check($sformatf("vec%0d_addr", idx), 32'(addr), 32'(v.exp_addr));
      check($sformatf("vec%0d_flags", idx),
            32'({four_bit, two_line, display_on, cursor_on, blink_on}), 32'(v.exp_flags));
      check($sformatf("vec%0d_overrun", idx), 32'(overrun), 32'h0);
   endtask

   initial begin
      int  busy_cnt;
      logic saw_busy;

      vecs[0]  = '{1'b0, 1'b0, 8'h30, 7'h00, F0};
      vecs[1]  = '{1'b0, 1'b0, 8'h30, 7'h00, F0};
      vecs[2]  = '{1'b0, 1'b0, 8'h30, 7'h00, F0};
      vecs[3]  = '{1'b0, 1'b0, 8'h20, 7'h00, F8};
      vecs[4]  = '{1'b1, 1'b0, 8'h28, 7'h00, F28};
      vecs[5]  = '{1'b1, 1'b0, 8'h0C, 7'h00, FON};
      vecs[6]  = '{1'b1, 1'b0, 8'h06, 7'h00, FON};
      vecs[7]  = '{1'b1, 1'b0, 8'hC4, 7'h44, FON};
      vecs[8]  = '{1'b1, 1'b1, 8'h31, 7'h45, FON};
      vecs[9]  = '{1'b1, 1'b1, 8'h32, 7'h46, FON};
      vecs[10] = '{1'b1, 1'b0, 8'hA7, 7'h27, FON};
      vecs[11] = '{1'b1, 1'b1, 8'h41, 7'h40, FON};
      vecs[12] = '{1'b1, 1'b0, 8'hCF, 7'h4F, FON};
      vecs[13] = '{1'b1, 1'b1, 8'h5A, 7'h50, FON};
      vecs[14] = '{1'b1, 1'b0, 8'h04, 7'h50, FON};
      vecs[15] = '{1'b1, 1'b0, 8'h80, 7'h00, FON};
      vecs[16] = '{1'b1, 1'b1, 8'h33, 7'h67, FON};
      vecs[17] = '{1'b1, 1'b0, 8'hC0, 7'h40, FON};
      vecs[18] = '{1'b1, 1'b1, 8'h34, 7'h27, FON};
      vecs[19] = '{1'b1, 1'b0, 8'h06, 7'h27, FON};
      vecs[20] = '{1'b1, 1'b0, 8'hE7, 7'h67, FON};
      vecs[21] = '{1'b1, 1'b1, 8'h35, 7'h00, FON};
      vecs[22] = '{1'b1, 1'b0, 8'h85, 7'h05, FON};
      vecs[23] = '{1'b1, 1'b0, 8'h02, 7'h00, FON};
      vecs[24] = '{1'b1, 1'b0, 8'h0F, 7'h00, FALL};
      vecs[25] = '{1'b1, 1'b0, 8'h4A, 7'h00, FALL};
      vecs[26] = '{1'b1, 1'b0, 8'h0C, 7'h00, FON};
      vecs[27] = '{1'b1, 1'b0, 8'h85, 7'h05, FON};
      vecs[28] = '{1'b1, 1'b0, 8'h14, SHIFT_R_ADDR, FON};
      vecs[29] = '{1'b1, 1'b0, 8'h10, 7'h05, FON};
      vecs[30] = '{1'b1, 1'b0, 8'h18, 7'h05, FON};
      vecs[31] = '{1'b1, 1'b0, 8'h00, 7'h05, FON};

      lcd_bus.en   = 1'b0;
      lcd_bus.rs   = 1'b0;
      lcd_bus.data = 4'h0;
      rd_row       = 1'b0;
      rd_col       = 6'd0;
      reset        = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values.
      check("rst_addr", 32'(addr), 32'h0);
      check("rst_flags", 32'({four_bit, two_line, display_on, cursor_on, blink_on}), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_byte", 32'({byte_valid, byte_rs, byte_data}), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_rd_char", 32'(rd_char), 32'h20);

      // Reset-triggered clear walk keeps busy low and leaves spaces behind.
      @(negedge clk);
      reset    = 1'b0;
      saw_busy = 1'b0;
      repeat (2 * COLS + 8) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      check("init_walk_busy", 32'(saw_busy), 32'h0);
      read_cell(1'b0, 6'd0, 8'h20, "init_r0c0");
      read_cell(1'b1, 6'd15, 8'h20, "init_r1c15");
      read_cell(1'b0, 6'd20, 8'h20, "init_col_oob");

      for (int i = 0; i < SPLIT; i++) apply_vec(vecs[i], i);

      // Latency: byte_valid appears on the third clock edge after raw en falls.
      sb_q.push_back('{rs: 1'b0, b: 8'h0C});
      send_nib(1'b0, 4'h0);
      @(negedge clk);
      lcd_bus.data = 4'hC;
      lcd_bus.en   = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 lcd_bus.en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("latency_early", 32'(byte_valid), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("latency_on_time", 32'(byte_valid), 32'h1);
      repeat (3) @(negedge clk);

      // Clear display: busy for exactly CLEAR_CYCLES cycles.
      sb_q.push_back('{rs: 1'b0, b: 8'h01});
      send_nib(1'b0, 4'h0);
      @(negedge clk);
      lcd_bus.data = 4'h1;
      lcd_bus.en   = 1'b1;
      repeat (3) @(negedge clk);
      lcd_bus.en = 1'b0;
      busy_cnt   = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         else if (busy_cnt > 0) break;
      end
      check("clear_busy_cycles", 32'(busy_cnt), 32'(CLEAR_CYCLES));
      check("clear_addr", 32'(addr), 32'h0);

      for (int i = SPLIT; i < N_VEC; i++) apply_vec(vecs[i], i);

      read_cell(1'b1, 6'd4, 8'h31, "rd_r1c4");
      read_cell(1'b1, 6'd5, 8'h32, "rd_r1c5");
      read_cell(1'b1, 6'd15, 8'h5A, "rd_r1c15");
      read_cell(1'b0, 6'd0, 8'h33, "rd_r0c0");
      read_cell(1'b1, 6'd0, 8'h34, "rd_r1c0");
      read_cell(1'b0, 6'd15, 8'h20, "rd_r0c15");
      read_cell(1'b1, 6'd1, 8'h20, "rd_r1c1");
      read_cell(1'b1, 6'd16, 8'h20, "rd_col_oob");

      // A data byte arriving during clear is reported but not executed.
      send4(1'b0, 8'h01);
      send4(1'b1, 8'h39);
      check("ovr_busy", 32'(busy), 32'h1);
      check("ovr_flag", 32'(overrun), 32'h1);
      check("ovr_addr", 32'(addr), 32'h0);
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check("ovr_clear_done", 32'(busy), 32'h0);
      read_cell(1'b0, 6'd0, 8'h20, "ovr_r0c0");
      check("ovr_sticky", 32'(overrun), 32'h1);

      // Reset during a clear walk aborts it; the reset walk then clears DDRAM.
      send4(1'b0, 8'hCF);
      send4(1'b1, 8'h44);
      read_cell(1'b1, 6'd15, 8'h44, "pre_rst_r1c15");
      send4(1'b0, 8'h01);
      repeat (5) @(negedge clk);
      check("mid_clr_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_addr", 32'(addr), 32'h0);
      check("mid_rst_four_bit", 32'(four_bit), 32'h0);
      check("mid_rst_overrun", 32'(overrun), 32'h0);
      repeat (3) @(negedge clk);
      reset    = 1'b0;
      saw_busy = 1'b0;
      repeat (2 * COLS + 8) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      check("rst_walk_busy", 32'(saw_busy), 32'h0);
      read_cell(1'b1, 6'd15, 8'h20, "rst_walk_r1c15");

      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hd44780_rx.md
Name: hd44780_rx

Overview:
- Responder-side model of an HD44780 character LCD in 4-bit bus mode.
- Samples en/rs/data from the LCD driver, reassembles nibbles into bytes, and executes the command subset the driver uses. Maintains an internal 2-row DDRAM image.
- Exposes the DDRAM image and mode flags to on-chip consumers: self-check logic, debug readout, or a future segment/VGA mirror of the LCD contents.

Parameters:
- COLS, 16, visible columns per row stored in DDRAM (1..40).
- CLEAR_CYCLES, 64, clk cycles busy asserts after clear display; must be >= 2*COLS.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  LCD enable strobe from driver; asynchronous to clk.
- rs  input  1  register select: 0 = command, 1 = data.
- data  input  4  LCD data bus DB7..DB4.
- rd_row  input  1  readout row select.
- rd_col  input  6  readout column, 0..COLS-1.
- rd_char  output  8  DDRAM byte at (rd_row, rd_col); registered, 1-cycle latency; 0x20 if rd_col >= COLS.
- addr  output  7  current DDRAM address counter.
- four_bit  output  1  1 = 4-bit interface mode.
- two_line  output  1  N bit from last function set.
- display_on  output  1  D bit.
- cursor_on  output  1  C bit.
- blink_on  output  1  B bit.
- busy  output  1  high while clear executes.
- byte_valid  output  1  one-cycle pulse per completed byte.
- byte_rs  output  1  rs of that byte.
- byte_data  output  8  that byte.
- overrun  output  1  sticky; set when a byte completes while busy.

Behaviour:
- Input path:
  - en, rs, data each pass through a 2-flop synchronizer.
  - A strobe is the falling edge of synchronized en. rs/data are captured from synchronized values at that cycle.
  - Strobe-to-byte_valid latency: 3 clk from the raw en falling edge.
- Reset values:
  - addr=0, four_bit=0, two_line=0, display_on=0, cursor_on=0, blink_on=0.
  - busy=0, byte_valid=0, byte_rs=0, byte_data=0, overrun=0, rd_char=0x20.
  - Nibble phase = HIGH.
  - DDRAM is all 0x20. It is filled by a reset-triggered clear walk, and busy is held low during that walk.
- Byte assembly:
  - 8-bit mode (four_bit=0): every strobe is a complete byte {data, 4'b0000}.
  - 4-bit mode: the HIGH strobe latches the upper nibble and its rs; the LOW strobe completes the byte. The byte uses the rs from the HIGH strobe; a mismatched rs on LOW is ignored.
- Command decode (rs=0), priority on the highest set bit:
  - 1xxxxxxx: addr <= byte[6:0].
  - 01xxxxxx: CGRAM address set; ignored.
  - 001xxxxx: four_bit <= ~byte[4]; two_line <= byte[3]. Phase resets to HIGH.
  - 0001xxxx: cursor/display shift; see Optional Feature.
  - 00001xxx: display_on/cursor_on/blink_on <= byte[2:0].
  - 000001xx: entry mode; incdec <= byte[1]; the shift bit is ignored.
  - 0000001x: addr <= 0.
  - 00000001: clear display. busy=1 for CLEAR_CYCLES; the FSM writes 0x20 to one location per cycle over 2*COLS cycles; addr <= 0 and incdec <= 1.
  - 0x00: no-op.
- Data write (rs=1):
  - Write byte_data to DDRAM if addr maps (row0: 0x00..COLS-1, row1: 0x40..0x40+COLS-1); otherwise drop the write.
  - Then step addr.
- Address stepping:
  - Increment wraps 0x27 -> 0x40 and 0x67 -> 0x00.
  - Decrement wraps 0x00 -> 0x67 and 0x40 -> 0x27.
- Clear FSM states:
  - IDLE -> CLR_WALK (2*COLS cycles) -> CLR_HOLD (remaining cycles) -> IDLE.
- Byte completing while busy:
  - byte_valid still pulses; the byte is not executed; overrun <= 1.
  - Nibble phase still advances.
- Readout:
  - A readout and a DDRAM write to the same location in the same cycle returns the old value.
- Reset asserted mid-operation:
  - Immediately returns all state to reset values and aborts any clear walk, which restarts after reset deasserts.

Optional Feature:
- Macro: LCD_SHIFT_EN.
- Defined: 0001 S/C R/L xx with S/C=0 steps addr by +1 (R/L=1) or -1 (R/L=0) using the wrap rules above. S/C=1 toggles no state but pulses byte_valid normally.
- Undefined: the whole 0001xxxx group is a no-op.

Test Plan:
- Reset, then strobes 3,3,3,2 (rs=0) -> four_bit=1 after the 4th; byte_valid data 0x30,0x30,0x30,0x20.
- 4-bit bytes 0x28,0x0C,0x06,0x01 -> two_line=1, display_on=1, cursor_on=0, blink_on=0; busy high for exactly 64 cycles; addr=0.
- Set addr 0xC4, then data 0x31,0x32 -> rd_row=1, rd_col=4 returns 0x31 and col 5 returns 0x32; addr=0x46.
- Data written at addr 0x27 -> no DDRAM change; addr=0x40. Entry mode 0x04, data at 0x00 -> addr=0x67.
- Data byte sent during clear busy -> overrun=1, DDRAM unchanged, byte_valid pulses.
- With LCD_SHIFT_EN: addr 0x05, cmd 0x14 -> addr 0x06; cmd 0x10 -> 0x05. Without the macro: addr stays 0x05.
